// File: rtl/step_vel_ramp.sv
// Per-axis velocity slew limiter with reversal guard and command watchdog.
// Sits between the SPI host command registers and the step pulse generator.
module step_vel_ramp #(
   parameter int unsigned TICK_DIV      = 1000,
   parameter int unsigned TIMEOUT_TICKS = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [15:0] cmd_vel,
   input  logic [15:0] accel,
   input  logic        enable_in,
   output logic [15:0] vel_out,
   output logic        enable_out,
   output logic        at_target,
   output logic        timeout_flag
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned WW = $clog2(TIMEOUT_TICKS + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_STOP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WW-1:0] wd_q, wd_d;
   logic [15:0]   vel_q, vel_d;
   logic [15:0]   target_q, target_d;
   logic          enable_q, enable_d;
   logic          at_tgt_q, at_tgt_d;
   logic          tflag_q, tflag_d;

   logic          tick_c;
   logic [16:0]   goal_c, cur_c, acc_c, diff_c, absd_c, nxt_c;
   logic [15:0]   step_c;

   assign tick_c = (cnt_q == CW'(TICK_DIV - 1));

   // One bounded step of V toward the goal, in 17-bit two's complement.
   always_comb begin
      goal_c = 17'd0;
      cur_c  = {vel_q[15], vel_q};
      acc_c  = {1'b0, accel};
      if (state_q == S_STOP) begin
         if (accel == 16'd0) acc_c = 17'd1;
      end else begin
         goal_c = {target_q[15], target_q};
      end
      diff_c = goal_c - cur_c;
      absd_c = diff_c[16] ? (17'd0 - diff_c) : diff_c;
      if (absd_c <= acc_c)  nxt_c = goal_c;
      else if (diff_c[16])  nxt_c = cur_c - acc_c;
      else                  nxt_c = cur_c + acc_c;
      // A reversal must pass through zero for one tick.
      if ((cur_c != 17'd0) && (nxt_c != 17'd0) && (nxt_c[16] != cur_c[16]))
         nxt_c = 17'd0;
      step_c = nxt_c[15:0];
   end

   // Next-state, watchdog and output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = tick_c ? '0 : cnt_q + CW'(1);
      wd_d     = wd_q;
      vel_d    = vel_q;
      target_d = target_q;
      tflag_d  = tflag_q;
      at_tgt_d = (state_q == S_RUN) && (vel_q == target_q);

      if (cmd_valid) begin
         target_d = (cmd_vel == 16'h8000) ? 16'h8001 : cmd_vel;
         tflag_d  = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            vel_d = 16'd0;
            wd_d  = '0;
            if (enable_in) state_d = S_RUN;
         end
         S_RUN: begin
            if (tick_c) vel_d = step_c;
            if (cmd_valid) begin
               wd_d = '0;
            end else if (tick_c) begin
               if ((wd_q + WW'(1)) == WW'(TIMEOUT_TICKS)) begin
                  wd_d    = '0;
                  state_d = S_STOP;
                  tflag_d = 1'b1;
               end else begin
                  wd_d = wd_q + WW'(1);
               end
            end
            if (!enable_in) state_d = S_STOP;
         end
         S_STOP: begin
            wd_d = '0;
            if (tick_c) begin
               vel_d = step_c;
               if (step_c == 16'd0) state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            vel_d   = 16'd0;
            wd_d    = '0;
         end
      endcase

      enable_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         wd_q     <= '0;
         vel_q    <= 16'd0;
         target_q <= 16'd0;
         enable_q <= 1'b0;
         at_tgt_q <= 1'b0;
         tflag_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wd_q     <= wd_d;
         vel_q    <= vel_d;
         target_q <= target_d;
         enable_q <= enable_d;
         at_tgt_q <= at_tgt_d;
         tflag_q  <= tflag_d;
      end
   end

   assign vel_out      = vel_q;
   assign enable_out   = enable_q;
   assign at_target    = at_tgt_q;
   assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_step_vel_ramp.sv
// Bench for step_vel_ramp: directed scenarios plus random traffic, all checked
// cycle by cycle against an integer reference model of the ramp rules.
module tb_step_vel_ramp;

   localparam int TD = 4;
   localparam int TO = 3;

   logic        clk, rst, cmd_valid, enable_in;
   logic [15:0] cmd_vel, accel;
   logic [15:0] vel_out;
   logic        enable_out, at_target, timeout_flag;

   int total = 0;
   int bad   = 0;

   step_vel_ramp #(.TICK_DIV(TD), .TIMEOUT_TICKS(TO)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_vel(cmd_vel),
      .accel(accel), .enable_in(enable_in), .vel_out(vel_out),
      .enable_out(enable_out), .at_target(at_target),
      .timeout_flag(timeout_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: 0 idle, 1 run, 2 stop.
   int m_state, m_vel, m_tgt, m_wd, m_cnt, m_at, m_flag;
   bit was_tick;
   bit ka;
   int ka_vel;
   bit cmd_req;
   int cmd_val;

   task automatic model_reset();
      m_state = 0; m_vel = 0; m_tgt = 0; m_wd = 0; m_cnt = 0; m_at = 0; m_flag = 0;
   endtask

   function automatic int step_f(int v, int g, int a);
      int d, nv;
      d = g - v;
      if ((d < 0 ? -d : d) <= a) nv = g;
      else nv = v + ((d < 0) ? -a : a);
      if ((v > 0 && nv < 0) || (v < 0 && nv > 0)) nv = 0;
      return nv;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive strobe, advance model, compare all outputs after the edge.
   task automatic cyc();
      bit tick, cv;
      int n_state, n_vel, n_tgt, n_wd, n_flag, n_at, a, c;
      cv = cmd_req || (ka && m_cnt == 0);
      cmd_valid = cv;
      if (cv) cmd_vel = 16'(cmd_req ? cmd_val : ka_vel);
      tick = (m_cnt == TD - 1);
      a = int'(accel);
      c = int'($signed(cmd_vel));
      n_state = m_state; n_vel = m_vel; n_wd = m_wd;
      n_at   = (m_state == 1 && m_vel == m_tgt);
      n_tgt  = cv ? ((c == -32768) ? -32767 : c) : m_tgt;
      n_flag = cv ? 0 : m_flag;
      if (m_state == 0) begin
         n_vel = 0; n_wd = 0;
         if (enable_in) n_state = 1;
      end else if (m_state == 1) begin
         if (tick) n_vel = step_f(m_vel, m_tgt, a);
         if (cv) n_wd = 0;
         else if (tick) begin
            n_wd = m_wd + 1;
            if (n_wd == TO) begin n_wd = 0; n_state = 2; n_flag = 1; end
         end
         if (!enable_in) n_state = 2;
      end else begin
         n_wd = 0;
         if (tick) begin
            n_vel = step_f(m_vel, 0, (a == 0) ? 1 : a);
            if (n_vel == 0) n_state = 0;
         end
      end
      @(posedge clk);
      #1;
      m_state = n_state; m_vel = n_vel; m_tgt = n_tgt; m_wd = n_wd;
      m_flag = n_flag; m_at = n_at; m_cnt = tick ? 0 : m_cnt + 1;
      was_tick = tick;
      cmd_valid = 1'b0;
      chk("vel_out", $signed(vel_out), m_vel);
      chk("enable_out", enable_out, (m_state != 0));
      chk("at_target", at_target, m_at);
      chk("timeout_flag", timeout_flag, m_flag);
   endtask

   task automatic next_tick();
      for (int i = 0; i < TD; i++) begin
         cyc();
         if (was_tick) break;
      end
   endtask

   task automatic send_cmd(input int v);
      ka_vel = v; cmd_val = v; cmd_req = 1'b1;
      cyc();
      cmd_req = 1'b0;
   endtask

   initial begin
      int found;
      rst = 1'b1; cmd_valid = 1'b0; cmd_vel = '0; accel = '0; enable_in = 1'b0;
      ka = 0; ka_vel = 0; cmd_req = 0; cmd_val = 0; was_tick = 0;
      model_reset();
      #12;
      chk("rst_vel", $signed(vel_out), 0);
      chk("rst_en", enable_out, 0);
      chk("rst_at", at_target, 0);
      chk("rst_flag", timeout_flag, 0);
      @(posedge clk); #1; rst = 1'b0;
      model_reset();

      // Ramp-up 0 -> 250 at 100 per tick.
      accel = 16'd100; enable_in = 1'b1; ka = 1;
      send_cmd(250);
      next_tick(); chk("ramp1", $signed(vel_out), 100);
      next_tick(); chk("ramp2", $signed(vel_out), 200);
      next_tick(); chk("ramp3", $signed(vel_out), 250);
      cyc();       chk("ramp_at", at_target, 1);

      // Reversal passes through zero.
      send_cmd(-250);
      next_tick(); chk("rev1", $signed(vel_out), 150);
      next_tick(); chk("rev2", $signed(vel_out), 50);
      next_tick(); chk("rev3", $signed(vel_out), 0);
      next_tick(); chk("rev4", $signed(vel_out), -100);
      next_tick(); chk("rev5", $signed(vel_out), -200);
      next_tick(); chk("rev6", $signed(vel_out), -250);

      // Watchdog stop from 200.
      send_cmd(200);
      for (int i = 0; i < 5; i++) next_tick();
      chk("wd_pre", $signed(vel_out), 200);
      ka = 0;
      for (int i = 0; i < 8; i++) begin
         next_tick();
         if (vel_out == 16'd0) break;
      end
      chk("wd_vel0", $signed(vel_out), 0);
      chk("wd_en0", enable_out, 0);
      chk("wd_flag", timeout_flag, 1);
      enable_in = 1'b0;
      send_cmd(200);
      chk("wd_flag_clr", timeout_flag, 0);

      // Enable drop from -300.
      enable_in = 1'b1; ka = 1;
      send_cmd(-300);
      next_tick(); chk("en_up1", $signed(vel_out), -100);
      next_tick(); chk("en_up2", $signed(vel_out), -200);
      next_tick(); chk("en_up3", $signed(vel_out), -300);
      enable_in = 1'b0; ka = 0;
      next_tick(); chk("drop1", $signed(vel_out), -200);
      next_tick(); chk("drop2", $signed(vel_out), -100);
      next_tick(); chk("drop3", $signed(vel_out), 0);
      chk("drop_en", enable_out, 0);
      enable_in = 1'b1; ka = 1; ka_vel = -300;
      next_tick(); chk("restart", $signed(vel_out), -100);

      // Edge values: clamp, accel 0 in RUN, accel 0 in STOP.
      accel = 16'hFFFF;
      send_cmd(-32768);
      next_tick(); chk("clamp", $signed(vel_out), -32767);
      accel = 16'd0;
      next_tick(); chk("hold1", $signed(vel_out), -32767);
      next_tick(); chk("hold2", $signed(vel_out), -32767);
      accel = 16'hFFFF;
      send_cmd(3);
      next_tick(); chk("big_guard", $signed(vel_out), 0);
      next_tick(); chk("to3", $signed(vel_out), 3);
      accel = 16'd0; enable_in = 1'b0; ka = 0;
      next_tick(); chk("stop_a0_1", $signed(vel_out), 2);
      next_tick(); chk("stop_a0_2", $signed(vel_out), 1);
      next_tick(); chk("stop_a0_3", $signed(vel_out), 0);
      chk("stop_a0_en", enable_out, 0);

      // cmd_valid on the expiry tick keeps the axis running.
      enable_in = 1'b1; accel = 16'd10;
      send_cmd(3);
      found = 0;
      for (int i = 0; i < 40; i++) begin
         if (m_state == 1 && m_cnt == TD - 1 && m_wd == TO - 1) begin
            cmd_val = 3; cmd_req = 1'b1;
            cyc();
            cmd_req = 1'b0;
            found = 1;
            break;
         end
         cyc();
      end
      chk("coinc_found", found, 1);
      chk("coinc_en", enable_out, 1);
      chk("coinc_flag", timeout_flag, 0);

      // Asynchronous reset mid-ramp.
      accel = 16'd50; ka = 1;
      send_cmd(150);
      for (int i = 0; i < 8; i++) begin
         next_tick();
         if ($signed(vel_out) == 150) break;
      end
      chk("pre_rst", $signed(vel_out), 150);
      #2 rst = 1'b1;
      #1;
      chk("arst_vel", $signed(vel_out), 0);
      chk("arst_en", enable_out, 0);
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      model_reset();
      ka = 0; enable_in = 1'b0;
      cyc(); cyc();
      chk("post_rst_en", enable_out, 0);
      enable_in = 1'b1;
      cyc(); cyc();
      chk("post_rst_tgt0", at_target, 1);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         enable_in = ($urandom_range(0, 24) != 0);
         if ($urandom_range(0, 7) == 0)
            accel = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 400));
         cmd_req = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 3))
            0:       cmd_val = -32768;
            1:       cmd_val = int'($signed(16'($urandom)));
            default: cmd_val = $urandom_range(0, 1200) - 600;
         endcase
         cyc();
         cmd_req = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/step_vel_ramp.md
# step_vel_ramp

Per-axis velocity slew limiter and command watchdog, placed between the SPI host controller (which writes per-axis velocity commands once per frame) and the step pulse generator (which consumes a signed velocity and emits step/dir).
- It ramps its output toward the latest commanded velocity at a bounded acceleration.
- It forces a zero crossing on reversal.
- It ramps the axis to a stop if the host stops refreshing commands or drops enable.

## Interface
- TICK_DIV, 1000: clk cycles per ramp update tick (≥2).
- TIMEOUT_TICKS, 100: ticks without cmd_valid before a watchdog stop (≥1).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  one-cycle strobe; captures cmd_vel.
- cmd_vel  in  16  signed target velocity; -32768 clamped to -32767 on capture.
- accel  in  16  unsigned max |Δvel| per tick; sampled at each tick.
- enable_in  in  1  host axis enable.
- vel_out  out  16  signed velocity to step generator, registered.
- enable_out  out  1  driver enable to step generator, registered.
- at_target  out  1  registered; 1 when state RUN and vel_out == target.
- timeout_flag  out  1  sticky watchdog-stop indicator, registered.

## Operation
- States: IDLE, RUN, STOP.
- IDLE:
  - vel_out = 0, enable_out = 0.
  - cmd_valid still captures target.
  - enable_in = 1 → RUN; enable_out goes 1 on entry.
- RUN: at each tick, vel_out steps toward target.
- STOP: at each tick, vel_out steps toward 0, ignoring target. When vel_out == 0 at a tick → IDLE, enable_out → 0.
- RUN → STOP when enable_in = 0 or the watchdog expires.
- STOP → RUN only via IDLE; cmd_valid during STOP updates target only.
- Step rule, with goal G (target in RUN, 0 in STOP) and current V:
  - D = G − V, computed 17-bit signed.
  - If |D| ≤ accel, then V' = G; otherwise V' = V + sign(D)·accel. No overflow is possible because both endpoints are within ±32767.
  - Reversal guard: if V ≠ 0 and V' has the opposite sign to V, then V' = 0 for that tick. The next tick continues from 0.
  - accel = 0: V holds, except in STOP, where accel = 0 is treated as 1 so a stop always completes.
- Watchdog:
  - Counts ticks while in RUN. Cleared by cmd_valid, and cleared on entering RUN.
  - Reaching TIMEOUT_TICKS → STOP and timeout_flag = 1.
  - timeout_flag clears on the next cmd_valid.
- Simultaneous events:
  - cmd_valid on a tick cycle: the watchdog is cleared and the tick uses the old target.
  - cmd_valid on the same cycle the watchdog would expire: cmd_valid wins, no stop.
  - enable_in = 0 and watchdog expiry together: STOP, timeout_flag = 1.

## Timing
- Reset values: vel_out = 0, enable_out = 0, at_target = 0, timeout_flag = 0, state = IDLE, target = 0, tick counter = 0, watchdog = 0.
- The tick counter is free-running 0..TICK_DIV−1 from reset. tick = 1 on the cycle where the counter = TICK_DIV−1.
- Captured target is visible one cycle after cmd_valid.
- vel_out, enable_out and state all update on the clock edge ending a tick cycle, so latency is tick + 1 clk.
- at_target is updated every cycle from registered state.
- enable_in is sampled every cycle; RUN→STOP takes 1 clk.
- IDLE→RUN takes 1 clk. The first vel_out change occurs at the next tick.
- rst mid-ramp: all outputs reach their reset values asynchronously; no ramp-down is performed.

## Test plan
- Ramp-up (TICK_DIV = 4, accel = 100, enable_in = 1, cmd 250) → vel_out 100, 200, 250 on successive ticks; at_target = 1 after the third tick.
- Reversal (V = 250, cmd −250, accel = 100) → 150, 50, 0 (guard), −100, −200, −250. vel_out never jumps from 50 to −50.
- Watchdog (TIMEOUT_TICKS = 3, V = 200, accel = 100, no cmd) → STOP after 3 ticks, then 100, 0; enable_out = 0 on the tick reaching 0, timeout_flag = 1. A later cmd_valid clears timeout_flag.
- Enable drop (V = −300, accel = 100, enable_in = 0) → −200, −100, 0, then IDLE with enable_out = 0. Re-asserting enable_in restarts from 0.
- Edge values:
  - cmd −32768 → target −32767.
  - accel = 0 in RUN → vel_out holds.
  - accel = 0 in STOP from 3 → 2, 1, 0.
  - cmd_valid coincident with watchdog expiry → stays in RUN.
- rst asserted mid-ramp at V = 150 → vel_out = 0 and enable_out = 0 immediately, with no clock required. After release, the block is in IDLE with target = 0.
